// File: rtl/cpu_sequencer.sv
// cpu_sequencer: microcoded-style fetch/decode/execute control FSM for a small accumulator CPU.
module cpu_sequencer #(
  parameter int OP_W     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_rdy,
  input  logic            run,
  input  logic            step,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_MAR,
  output logic            Addr_bus,
  output logic            CS,
  output logic            R_NW,
  output logic            load_MDR,
  output logic            MDR_bus,
  output logic            load_IR,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            SW_bus,
  output logic            load_DISP,
  output logic [1:0]      alu_op,
  output logic            halted,
  output logic            bus_err
);
  localparam int CW = ($clog2(WAIT_MAX + 1) < 4) ? 4 : $clog2(WAIT_MAX + 1);
  localparam logic [OP_W-1:0] LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] STORE = OP_W'(1);
  localparam logic [OP_W-1:0] ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] BNE   = OP_W'(4);
  localparam logic [OP_W-1:0] IN    = OP_W'(5);
  localparam logic [OP_W-1:0] OUT   = OP_W'(6);

  typedef enum logic [2:0] {IDLE, F1, F2, F3, DEC, E1, E2, HLT} state_t;

  typedef struct packed {
    logic       pc_bus;
    logic       load_pc;
    logic       inc_pc;
    logic       load_mar;
    logic       addr_bus;
    logic       cs;
    logic       r_nw;
    logic       load_mdr;
    logic       mdr_bus;
    logic       load_ir;
    logic       acc_bus;
    logic       load_acc;
    logic       sw_bus;
    logic       load_disp;
    logic [1:0] alu_op;
  } ctl_t;

  state_t          state, state_n, end_n;
  logic [OP_W-1:0] op_q;
  logic [CW-1:0]   cnt;
  logic            waiting, timeout;
  ctl_t            c;

  assign waiting = (state == F2) || (state == E1 && op_q != STORE) || (state == E2 && op_q == STORE);
  // The limit is hit on the WAIT_MAX-th consecutive cycle without mem_rdy.
  assign timeout = waiting && !mem_rdy && (cnt == CW'(WAIT_MAX - 1));
  assign end_n   = run ? F1 : IDLE;
  assign halted  = (state == HLT);
  assign {PC_bus, load_PC, INC_PC, load_MAR, Addr_bus, CS, R_NW, load_MDR, MDR_bus,
          load_IR, ACC_bus, load_ACC, SW_bus, load_DISP, alu_op} = reset ? '0 : c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DEC) op_q <= op;
      cnt <= (waiting && state_n == state) ? cnt + 1'b1 : '0;
      if (timeout) bus_err <= 1'b1;
    end
  end

  always_comb begin
    c       = '0;
    state_n = state;
    case (state)
      IDLE: state_n = (run || step) ? F1 : IDLE;
      F1: begin
        c.pc_bus   = 1'b1;
        c.load_mar = 1'b1;
        state_n    = F2;
      end
      F2: begin
        c.cs       = 1'b1;
        c.r_nw     = 1'b1;
        c.load_mdr = mem_rdy;
        c.inc_pc   = mem_rdy;
        c.load_pc  = mem_rdy;
        state_n    = mem_rdy ? F3 : timeout ? HLT : F2;
      end
      F3: begin
        c.mdr_bus = 1'b1;
        c.load_ir = 1'b1;
        state_n   = DEC;
      end
      DEC: begin
        if (op == LOAD || op == STORE || op == ADD || op == SUB) begin
          c.addr_bus = 1'b1;
          c.load_mar = 1'b1;
          state_n    = E1;
        end else if (op == BNE) begin
          c.addr_bus = !z_flag;
          c.load_pc  = !z_flag;
          state_n    = end_n;
        end else if (op == IN) begin
          c.sw_bus   = 1'b1;
          c.load_acc = 1'b1;
          state_n    = end_n;
        end else if (op == OUT) begin
          c.acc_bus   = 1'b1;
          c.load_disp = 1'b1;
          state_n     = end_n;
        end else begin
          state_n = HLT;
        end
      end
      E1: begin
        if (op_q == STORE) begin
          c.acc_bus  = 1'b1;
          c.load_mdr = 1'b1;
          state_n    = E2;
        end else begin
          c.cs       = 1'b1;
          c.r_nw     = 1'b1;
          c.load_mdr = mem_rdy;
          state_n    = mem_rdy ? E2 : timeout ? HLT : E1;
        end
      end
      E2: begin
        if (op_q == STORE) begin
          c.cs    = 1'b1;
          state_n = mem_rdy ? end_n : timeout ? HLT : E2;
        end else begin
          c.mdr_bus  = 1'b1;
          c.load_acc = 1'b1;
          c.alu_op   = (op_q == ADD) ? 2'b01 : (op_q == SUB) ? 2'b10 : 2'b00;
          state_n    = end_n;
        end
      end
      HLT: state_n = HLT;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle checks of cpu_sequencer control outputs and status.
module tb_cpu_sequencer;
  logic clock = 1'b0, reset = 1'b1;
  logic [2:0] op = '0;
  logic z_flag = 1'b0, mem_rdy = 1'b0, run = 1'b0, step = 1'b0;
  logic PC_bus, load_PC, INC_PC, load_MAR, Addr_bus, CS, R_NW, load_MDR, MDR_bus;
  logic load_IR, ACC_bus, load_ACC, SW_bus, load_DISP, halted, bus_err;
  logic [1:0] alu_op;
  logic [15:0] ctl;
  int checks = 0, failures = 0;

  cpu_sequencer #(.OP_W(3), .WAIT_MAX(15)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_rdy(mem_rdy),
    .run(run), .step(step), .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC),
    .load_MAR(load_MAR), .Addr_bus(Addr_bus), .CS(CS), .R_NW(R_NW), .load_MDR(load_MDR),
    .MDR_bus(MDR_bus), .load_IR(load_IR), .ACC_bus(ACC_bus), .load_ACC(load_ACC),
    .SW_bus(SW_bus), .load_DISP(load_DISP), .alu_op(alu_op), .halted(halted), .bus_err(bus_err)
  );

  assign ctl = {PC_bus, load_PC, INC_PC, load_MAR, Addr_bus, CS, R_NW, load_MDR, MDR_bus,
                load_IR, ACC_bus, load_ACC, SW_bus, load_DISP, alu_op};

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_rdy = 1'b0; z_flag = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; step = 1'b1; mem_rdy = 1'b1;
    tick();
    #1;
    checks++;
    if ({ctl, halted, bus_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_during ctl/halted/err=%h exp=0", {ctl, halted, bus_err});
    end
    reset = 1'b0; run = 1'b0; step = 1'b0;
    tick();
    checks++;
    if ({ctl, halted, bus_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_after ctl/halted/err=%h exp=0", {ctl, halted, bus_err});
    end
  endtask

  task automatic test_add_run();
    logic [15:0] e [8];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h1800, 16'h0700, 16'h0091, 16'h9000};
    pulse_reset();
    run = 1'b1; mem_rdy = 1'b1; op = 3'b010;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL add_run cyc%0d ctl=%h exp=%h", i, ctl, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_bne_step();
    logic [15:0] e [13];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h4800, 16'h0000, 16'h0000,
          16'h9000, 16'h6700, 16'h00C0, 16'h0000, 16'h0000, 16'h0000};
    pulse_reset();
    op = 3'b100; mem_rdy = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step = (i == 0 || i == 6);
      z_flag = (i >= 6);
      #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL bne_step cyc%0d ctl=%h exp=%h", i, ctl, e[i]);
      end
      tick();
    end
    step = 1'b0;
  endtask

  task automatic test_store_wait();
    logic [15:0] e [11];
    logic r [11];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h1800, 16'h0120,
          16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h9000};
    r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pulse_reset();
    run = 1'b1; op = 3'b001;
    for (int i = 0; i < 11; i++) begin
      mem_rdy = r[i];
      #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL store_wait cyc%0d ctl=%h exp=%h", i, ctl, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e [22];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h0018,
          16'h9000, 16'h6700, 16'h00C0, 16'h0024,
          16'h9000, 16'h6700, 16'h00C0, 16'h1800, 16'h0700, 16'h0092,
          16'h9000, 16'h6700, 16'h00C0, 16'h1800, 16'h0700, 16'h0090, 16'h9000};
    pulse_reset();
    run = 1'b1; mem_rdy = 1'b1;
    for (int i = 0; i < 22; i++) begin
      op = (i < 5) ? 3'd5 : (i < 9) ? 3'd6 : (i < 13) ? 3'd3 : (i < 18) ? 3'd5 : (i == 18) ? 3'd0 : 3'd6;
      #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL back_to_back cyc%0d ctl=%h exp=%h", i, ctl, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_bus_err();
    logic [15:0] x;
    pulse_reset();
    run = 1'b1; mem_rdy = 1'b0; op = 3'b010;
    for (int i = 0; i < 17; i++) begin
      x = (i == 0) ? 16'h0000 : (i == 1) ? 16'h9000 : 16'h0600;
      #1;
      checks++;
      if ({ctl, halted, bus_err} !== {x, 2'b00}) begin
        failures++;
        $display("FAIL bus_err_wait cyc%0d ctl/halted/err=%h exp=%h", i, {ctl, halted, bus_err}, {x, 2'b00});
      end
      tick();
    end
    run = 1'b1; step = 1'b1; mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ctl, halted, bus_err} !== {16'h0, 2'b11}) begin
        failures++;
        $display("FAIL bus_err_hlt cyc%0d ctl/halted/err=%h exp=%h", i, {ctl, halted, bus_err}, {16'h0, 2'b11});
      end
      tick();
    end
    pulse_reset();
    #1;
    checks++;
    if ({halted, bus_err} !== 2'b00) begin
      failures++;
      $display("FAIL bus_err_clear halted/err=%b exp=00", {halted, bus_err});
    end
  endtask

  task automatic test_wait_boundary();
    logic [15:0] x;
    pulse_reset();
    run = 1'b1; op = 3'b101;
    for (int i = 0; i < 18; i++) begin
      mem_rdy = (i == 16);
      x = (i == 0) ? 16'h0000 : (i == 1) ? 16'h9000 : (i < 16) ? 16'h0600 : (i == 16) ? 16'h6700 : 16'h00C0;
      #1;
      checks++;
      if ({ctl, halted, bus_err} !== {x, 2'b00}) begin
        failures++;
        $display("FAIL wait_boundary cyc%0d ctl/halted/err=%h exp=%h", i, {ctl, halted, bus_err}, {x, 2'b00});
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] e [6];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h0000, 16'h0000};
    pulse_reset();
    run = 1'b1; mem_rdy = 1'b1; op = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if ({ctl, halted} !== {e[i], i == 5}) begin
        failures++;
        $display("FAIL halt cyc%0d ctl/halted=%h exp=%h", i, {ctl, halted}, {e[i], i == 5});
      end
      tick();
    end
    run = 1'b0; reset = 1'b1;
    #1;
    checks++;
    if ({ctl, halted} !== {16'h0, 1'b1}) begin
      failures++;
      $display("FAIL halt_in_reset ctl/halted=%h exp=%h", {ctl, halted}, {16'h0, 1'b1});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({ctl, halted, bus_err} !== 18'h0) begin
      failures++;
      $display("FAIL halt_exit ctl/halted/err=%h exp=0", {ctl, halted, bus_err});
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [15:0] e [7];
    e = '{16'h0000, 16'h9000, 16'h6700, 16'h00C0, 16'h1800, 16'h0600, 16'h0600};
    pulse_reset();
    run = 1'b1; op = 3'b000;
    for (int i = 0; i < 7; i++) begin
      mem_rdy = (i < 5);
      #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL mid_wait cyc%0d ctl=%h exp=%h", i, ctl, e[i]);
      end
      tick();
    end
    reset = 1'b1; mem_rdy = 1'b1;
    #1;
    checks++;
    if (ctl !== 16'h0) begin
      failures++;
      $display("FAIL mid_wait_reset ctl=%h exp=0000", ctl);
    end
    tick();
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({ctl, halted, bus_err} !== 18'h0) begin
        failures++;
        $display("FAIL mid_wait_idle cyc%0d ctl/halted/err=%h exp=0", i, {ctl, halted, bus_err});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add_run();
    test_bne_step();
    test_store_wait();
    test_back_to_back();
    test_bus_err();
    test_wait_boundary();
    test_halt();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
